ms_rr_arbiter: RTL

- Round-robin arbiter sharing one blocking master output channel (integer data plus sync/notify handshake) among NUM_REQ requesting master ports.
- Sits between several producer blocks and a single consumer slave port; the consumer sees one ordinary master port.
- Section-based controller (section_idle / section_send) in the same style as the generated master/slave modules.

---
 rtl/ms_rr_arbiter_pkg.sv | 14 +
 rtl/ms_rr_arbiter_if.sv | 29 ++
 rtl/ms_rr_arbiter_pick.sv | 45 ++++
 rtl/ms_rr_arbiter.sv | 102 ++++++++++
 4 files changed

// File: rtl/ms_rr_arbiter_pkg.sv
// Shared types for the round-robin arbiter: controller sections, word type, counter width.
package ms_rr_arbiter_types;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned XFER_CNT_W = 16;

  typedef logic signed [WORD_W-1:0] word_t;

  typedef enum logic {
    section_idle,
    section_send
  } MS_RR_ARBITER_SECTIONS;

endpackage

// File: rtl/ms_rr_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the consumer.
// master = arbiter side, slave = requester/consumer side.
interface ms_rr_arbiter_if
  import ms_rr_arbiter_types::*;
#(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  word_t                  m_in [NUM_REQ];
  logic [NUM_REQ-1:0]     m_in_sync;
  logic [NUM_REQ-1:0]     m_in_notify;
  word_t                  s_out;
  logic                   s_out_sync;
  logic                   s_out_notify;
  logic [IDX_W-1:0]       grant_id;
  logic [XFER_CNT_W-1:0]  xfer_cnt;

  modport master (
    input  m_in, m_in_sync, s_out_notify,
    output m_in_notify, s_out, s_out_sync, grant_id, xfer_cnt
  );

  modport slave (
    output m_in, m_in_sync, s_out_notify,
    input  m_in_notify, s_out, s_out_sync, grant_id, xfer_cnt
  );

endinterface

// File: rtl/ms_rr_arbiter_pick.sv
// Combinational winner selection: rotate past last_grant and take the first request.
// MS_ARB_FIXED_PRIO_EN selects plain lowest-index priority instead.
module ms_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               any_req,
  output logic [IDX_W-1:0]   pick_idx
);

  assign any_req = |req;

`ifdef MS_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  // Descending scan so the lowest requesting index is the last write.
  always_comb begin
    pick_idx = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[IDX_W'(i)]) pick_idx = IDX_W'(i);
    end
  end
`else
  logic [IDX_W-1:0] cand;
  logic             found;

  // Search last_grant+1, +2, ... wrapping; last_grant itself is checked last.
  always_comb begin
    pick_idx = '0;
    cand     = '0;
    found    = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_grant) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end
`endif

endmodule

// File: rtl/ms_rr_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ blocking master ports onto one output channel.
// Define MS_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module ms_rr_arbiter
  import ms_rr_arbiter_types::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  ms_rr_arbiter_if.master bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  MS_RR_ARBITER_SECTIONS    section_q, section_d;
  word_t                    s_out_q, s_out_d;
  logic                     sync_q, sync_d;
  logic [NUM_REQ-1:0]       notify_q, notify_d;
  logic [IDX_W-1:0]         grant_q, grant_d;
  logic [XFER_CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]         last_q;
  logic                     any_req;
  logic [IDX_W-1:0]         pick_idx;

  ms_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (bus.m_in_sync),
    .last_grant (last_q),
    .any_req    (any_req),
    .pick_idx   (pick_idx)
  );

`ifdef MS_ARB_FIXED_PRIO_EN
  assign last_q = IDX_W'(NUM_REQ - 1);
`else
  logic [IDX_W-1:0] last_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= IDX_W'(NUM_REQ - 1);
    else     last_q <= last_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      section_q <= section_idle;
      s_out_q   <= '0;
      sync_q    <= 1'b0;
      notify_q  <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
    end else begin
      section_q <= section_d;
      s_out_q   <= s_out_d;
      sync_q    <= sync_d;
      notify_q  <= notify_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
    end
  end

  // Accept one word in idle; wait for the consumer in send. Notify is a single-cycle pulse.
  always_comb begin
    section_d = section_q;
    s_out_d   = s_out_q;
    sync_d    = sync_q;
    notify_d  = '0;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
`ifndef MS_ARB_FIXED_PRIO_EN
    last_d    = last_q;
`endif
    unique case (section_q)
      section_idle: begin
        if (any_req) begin
          s_out_d            = bus.m_in[pick_idx];
          grant_d            = pick_idx;
          sync_d             = 1'b1;
          notify_d[pick_idx] = 1'b1;
          section_d          = section_send;
        end
      end
      section_send: begin
        if (bus.s_out_notify) begin
          sync_d    = 1'b0;
          cnt_d     = cnt_q + XFER_CNT_W'(1);
`ifndef MS_ARB_FIXED_PRIO_EN
          last_d    = grant_q;
`endif
          section_d = section_idle;
        end
      end
      default: section_d = section_idle;
    endcase
  end

  assign bus.s_out       = s_out_q;
  assign bus.s_out_sync  = sync_q;
  assign bus.m_in_notify = notify_q;
  assign bus.grant_id    = grant_q;
  assign bus.xfer_cnt    = cnt_q;

endmodule
